// File: rtl/memory_access_unit.sv
// Memory-stage access controller for the y86 pipeline: decodes the M-stage
// instruction, runs one req/ack data-memory access per instruction and reports valM/stat.
module memory_access_unit #(
    parameter logic [63:0] MEM_SIZE = 64'h2000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  M_stat_i,
    input  logic [3:0]  M_icode_i,
    input  logic [63:0] M_valE_i,
    input  logic [63:0] M_valA_i,
    input  logic        mem_advance_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [63:0] dmem_addr_o,
    output logic [63:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [63:0] dmem_rdata_i,
    input  logic        dmem_err_i,
    output logic [63:0] m_valM_o,
    output logic [2:0]  m_stat_o,
    output logic        m_busy_o
);

    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SADR = 3'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic        req_we_q, req_we_d;
    logic [63:0] req_addr_q, req_addr_d;
    logic [63:0] req_wdata_q, req_wdata_d;
    logic [63:0] valM_q, valM_d;
    logic        err_q, err_d;

    logic        is_read;
    logic        is_write;
    logic [63:0] acc_addr;
    logic        stat_ok;
    logic        in_range;
    logic        need_access;
    logic        addr_fault;
    logic        req_active;

    // Instruction decode is purely combinational from the M register.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        is_read  = 1'b0;
        is_write = 1'b0;
        case (M_icode_i)
            IMRMOVQ, IPOPQ, IRET:  is_read  = 1'b1;
            IRMMOVQ, IPUSHQ, ICALL: is_write = 1'b1;
            default: ;
        endcase
    end

    // Stack pops and returns address through valA; everything else through valE.
    assign acc_addr    = (M_icode_i == IPOPQ || M_icode_i == IRET) ? M_valA_i : M_valE_i;
    assign stat_ok     = (M_stat_i == SAOK);
    assign in_range    = (acc_addr < MEM_SIZE);
    assign need_access = (is_read || is_write) && stat_ok && in_range;
    assign addr_fault  = (is_read || is_write) && stat_ok && !in_range;

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
        if (rst_i) begin
            state_q     <= S_IDLE;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            valM_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            valM_q      <= valM_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        valM_d      = valM_q;
        err_d       = err_q;
        req_active  = 1'b0;
        m_busy_o    = 1'b0;
        m_valM_o    = '0;
        m_stat_o    = M_stat_i;

        case (state_q)
            S_IDLE: begin
                if (addr_fault) begin
                    m_stat_o = SADR;
                end
                if (need_access) begin
                    m_busy_o    = 1'b1;
                    req_we_d    = is_write;
                    req_addr_d  = acc_addr;
                    req_wdata_d = is_write ? M_valA_i : '0;
                    valM_d      = '0;
                    err_d       = 1'b0;
                    state_d     = S_BUSY;
                end
            end
            S_BUSY: begin
                req_active = 1'b1;
                m_busy_o   = 1'b1;
                if (dmem_ack_i) begin
                    valM_d  = req_we_q ? 64'd0 : dmem_rdata_i;
                    err_d   = dmem_err_i;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Holding here until M advances keeps a stalled instruction from re-issuing.
                m_valM_o = valM_q;
                m_stat_o = err_q ? SADR : M_stat_i;
                if (mem_advance_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign dmem_req_o   = req_active;
    assign dmem_we_o    = req_active & req_we_q;
    assign dmem_addr_o  = req_active ? req_addr_q  : 64'd0;
    assign dmem_wdata_o = req_active ? req_wdata_q : 64'd0;

endmodule

// File: tb/tb_memory_access_unit.sv
// Scoreboard bench for memory_access_unit: driver pushes expected results from a
// behavioural memory model, a monitor compares whenever M commits or the bus is active.
`timescale 1ns/1ps
module tb_memory_access_unit;

    localparam logic [63:0] MEM_SIZE = 64'h2000;

    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  M_stat;
    logic [3:0]  M_icode;
    logic [63:0] M_valE, M_valA;
    logic        ext_stall;
    logic        mem_advance;
    logic        dmem_req, dmem_we, dmem_ack, dmem_err;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [63:0] m_valM;
    logic [2:0]  m_stat;
    logic        m_busy;

    // The pipeline advances M whenever the memory stage is not busy and nothing else stalls.
    assign mem_advance = ~m_busy & ~ext_stall;

    always #5 clk = ~clk;

    memory_access_unit #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .M_stat_i     (M_stat),
        .M_icode_i    (M_icode),
        .M_valE_i     (M_valE),
        .M_valA_i     (M_valA),
        .mem_advance_i(mem_advance),
        .dmem_req_o   (dmem_req),
        .dmem_we_o    (dmem_we),
        .dmem_addr_o  (dmem_addr),
        .dmem_wdata_o (dmem_wdata),
        .dmem_ack_i   (dmem_ack),
        .dmem_rdata_i (dmem_rdata),
        .dmem_err_i   (dmem_err),
        .m_valM_o     (m_valM),
        .m_stat_o     (m_stat),
        .m_busy_o     (m_busy)
    );

    typedef struct {
        logic [2:0]  stat_in;
        logic [2:0]  stat;
        logic [63:0] valM;
        int          busy;
    } exp_out_t;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } exp_req_t;

    typedef struct {
        int          wt;
        logic        err;
        logic [63:0] rdata;
    } resp_t;

    exp_out_t exp_q[$];
    exp_req_t req_q[$];
    resp_t    resp_q[$];
    logic [63:0] mem [logic [63:0]];

    int vectors     = 0;
    int miscompares = 0;
    bit active      = 1'b0;
    bit resp_en     = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[31:0], ~a[31:0]};
    endfunction

    function automatic logic [63:0] rand_addr();
        case ($urandom_range(0, 5))
            0, 1, 2: return {51'd0, 10'($urandom_range(0, 1023)), 3'b000};
            3:       return MEM_SIZE - 64'd8;
            4:       return MEM_SIZE + 64'($urandom_range(0, 255));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Memory responder: plays back pre-planned latency/err/rdata for each request.
    initial begin
        int    cnt;
        bit    inflight;
        resp_t r;
        cnt = 0;
        inflight = 1'b0;
        dmem_ack = 1'b0;
        dmem_err = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !resp_en) begin
                inflight = 1'b0;
            end else begin
                dmem_ack   = 1'b0;
                dmem_err   = 1'b0;
                dmem_rdata = {$urandom, $urandom};
                if (dmem_req && !inflight && resp_q.size() > 0) begin
                    r = resp_q.pop_front();
                    cnt = r.wt;
                    inflight = 1'b1;
                end
                if (dmem_req && inflight) begin
                    if (cnt == 0) begin
                        dmem_ack   = 1'b1;
                        dmem_err   = r.err;
                        dmem_rdata = r.rdata;
                        inflight   = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    // Monitor: bus checks every cycle, result checks whenever M holds an instruction.
    initial begin
        int       busy_cnt;
        int       since_commit;
        bit       prev_req;
        exp_out_t eo;
        exp_req_t er;
        busy_cnt = 0;
        since_commit = 0;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || !active) begin
                busy_cnt = 0;
                since_commit = 0;
                prev_req = 1'b0;
            end else begin
                since_commit++;
                if (!dmem_req) begin
                    check("bus_idle_zero", dmem_addr | dmem_wdata | 64'(dmem_we), 64'd0);
                end else if (req_q.size() == 0) begin
                    check("unexpected_req", 64'(dmem_req), 64'd0);
                end else begin
                    er = req_q[0];
                    if (!prev_req) check("req_rise_delay", 64'(since_commit), 64'd2);
                    check("req_we", 64'(dmem_we), 64'(er.we));
                    check("req_addr", dmem_addr, er.addr);
                    if (er.we) check("req_wdata", dmem_wdata, er.wdata);
                    if (dmem_ack) void'(req_q.pop_front());
                end
                prev_req = dmem_req;
                if (exp_q.size() > 0) begin
                    eo = exp_q[0];
                    if (m_busy) begin
                        busy_cnt++;
                        check("busy_valM", m_valM, 64'd0);
                        check("busy_stat", 64'(m_stat), 64'(eo.stat_in));
                    end else begin
                        check("valM", m_valM, eo.valM);
                        check("stat", 64'(m_stat), 64'(eo.stat));
                        if (mem_advance) begin
                            check("busy_cycles", 64'(busy_cnt), 64'(eo.busy));
                            void'(exp_q.pop_front());
                            busy_cnt = 0;
                            since_commit = 0;
                        end
                    end
                end
            end
        end
    end

    // Loads one instruction into M; entered and left just after a posedge.
    task automatic run_instr(input logic [3:0] icode, input logic [2:0] stat,
                             input logic [63:0] valE, input logic [63:0] valA,
                             input int wt, input bit err, input int hold);
        bit          rd, wr;
        logic [63:0] addr;
        exp_out_t    eo;
        exp_req_t    er;
        resp_t       r;
        int          cycles;
        int          h;
        h    = hold;
        rd   = icode inside {IMRMOVQ, IPOPQ, IRET};
        wr   = icode inside {IRMMOVQ, IPUSHQ, ICALL};
        addr = (icode inside {IPOPQ, IRET}) ? valA : valE;
        eo.stat_in = stat;
        eo.stat    = stat;
        eo.valM    = '0;
        eo.busy    = 0;
        if ((rd || wr) && stat == SAOK) begin
            if (addr >= MEM_SIZE) begin
                eo.stat = SADR;
            end else begin
                r.wt    = wt;
                r.err   = err;
                r.rdata = rd ? mem_rd(addr) : {$urandom, $urandom};
                eo.valM = rd ? r.rdata : 64'd0;
                eo.stat = err ? SADR : SAOK;
                eo.busy = 2 + wt;
                if (wr && !err) mem[addr] = valA;
                er.we    = wr;
                er.addr  = addr;
                er.wdata = valA;
                req_q.push_back(er);
                resp_q.push_back(r);
            end
        end
        exp_q.push_back(eo);
        M_icode   = icode;
        M_stat    = stat;
        M_valE    = valE;
        M_valA    = valA;
        ext_stall = (h > 0);
        active    = 1'b1;
        cycles    = 0;
        forever begin
            @(negedge clk);
            if (mem_advance) break;
            if (!m_busy && h > 0) h--;
            cycles++;
            if (cycles > 200) begin
                check("advance_timeout", 64'(cycles), 64'd0);
                finish_run();
            end
            @(posedge clk);
            #1;
            ext_stall = (h > 0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        miscompares++;
        $display("FAIL global_timeout: simulation still running at t=%0t", $time);
        finish_run();
    end

    initial begin
        logic [2:0] alt_stat [3];
        logic [2:0] st;
        alt_stat = '{SHLT, SADR, SINS};
        rst       = 1'b1;
        ext_stall = 1'b0;
        M_icode   = IMRMOVQ;
        M_stat    = SAOK;
        M_valE    = 64'h100;
        M_valA    = 64'd0;
        mem[64'h100] = 64'hDEADBEEF;

        // Reset state: bus quiet, busy/stat follow the live decode.
        #12;
        check("rst_req", 64'(dmem_req), 64'd0);
        check("rst_bus", dmem_addr | dmem_wdata | 64'(dmem_we), 64'd0);
        check("rst_valM", m_valM, 64'd0);
        check("rst_busy_decode", 64'(m_busy), 64'd1);
        check("rst_stat_decode", 64'(m_stat), 64'(SAOK));
        M_icode = IRMMOVQ;
        M_valE  = 64'h2000;
        #1;
        check("rst_fault_stat", 64'(m_stat), 64'(SADR));
        check("rst_fault_busy", 64'(m_busy), 64'd0);

        @(posedge clk);
        #1;
        rst     = 1'b0;
        resp_en = 1'b1;

        // Directed scenarios.
        run_instr(IMRMOVQ, SAOK, 64'h100, 64'd0,  0, 1'b0, 0);
        run_instr(IPUSHQ,  SAOK, 64'h1F8, 64'h55, 3, 1'b0, 0);
        run_instr(IRMMOVQ, SAOK, 64'h2000, 64'h11, 0, 1'b0, 0);
        run_instr(IPOPQ,   SAOK, 64'd0,   64'h40, 1, 1'b1, 0);
        run_instr(IMRMOVQ, SINS, 64'h100, 64'd0,  0, 1'b0, 0);
        run_instr(IPOPQ,   SAOK, 64'd0,   64'h1F8, 0, 1'b0, 4);
        run_instr(IRET,    SAOK, 64'd0,   64'h100, 1, 1'b0, 0);
        run_instr(ICALL,   SAOK, 64'h1FF8, 64'h77, 2, 1'b0, 0);
        run_instr(INOP,    SAOK, 64'd0,   64'd0,  0, 1'b0, 0);

        // Randomised instruction stream.
        for (int i = 0; i < 300; i++) begin
            st = ($urandom_range(0, 9) < 7) ? SAOK : alt_stat[$urandom_range(0, 2)];
            run_instr(4'($urandom_range(0, 15)), st, rand_addr(), rand_addr(),
                      $urandom_range(0, 4), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end

        // Reset while a request is outstanding.
        active    = 1'b0;
        resp_en   = 1'b0;
        dmem_ack  = 1'b0;
        dmem_err  = 1'b0;
        ext_stall = 1'b0;
        M_icode   = IMRMOVQ;
        M_stat    = SAOK;
        M_valE    = 64'h300;
        @(posedge clk);
        #1;
        check("pre_rst_req", 64'(dmem_req), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_req", 64'(dmem_req), 64'd0);
        check("mid_rst_bus", dmem_addr | dmem_wdata | 64'(dmem_we), 64'd0);
        check("mid_rst_valM", m_valM, 64'd0);
        check("mid_rst_busy", 64'(m_busy), 64'd1);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        M_icode    = INOP;
        dmem_ack   = 1'b1;
        dmem_err   = 1'b1;
        dmem_rdata = 64'hBAD0BAD0;
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        dmem_err = 1'b0;
        check("post_rst_req", 64'(dmem_req), 64'd0);
        check("post_rst_busy", 64'(m_busy), 64'd0);
        check("post_rst_valM", m_valM, 64'd0);
        check("post_rst_stat", 64'(m_stat), 64'(SAOK));
        @(posedge clk);
        #1;
        check("post_rst_idle", 64'(dmem_req), 64'd0);

        resp_en = 1'b1;
        run_instr(IMRMOVQ, SAOK, 64'h100, 64'd0, 0, 1'b0, 0);
        run_instr(IPUSHQ,  SAOK, 64'h8,   64'h99, 1, 1'b0, 0);
        run_instr(IPOPQ,   SAOK, 64'd0,   64'h8, 0, 1'b0, 0);

        active = 1'b0;
        if (exp_q.size() != 0 || req_q.size() != 0)
            check("queues_drained", 64'(exp_q.size() + req_q.size()), 64'd0);
        finish_run();
    end

endmodule
